// File: rtl/ds1302_xfer.sv
// ds1302_xfer: one-byte command/data transfer engine for a DS1302 RTC.
// A one-hot request selects a command byte; the engine raises CE, waits the
// setup time, shifts 16 bits LSB first (command then data), and returns the
// read byte with a one-cycle done pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | CE low, line released, waiting for a nonzero request
// SETUP | CE high, SCLK low, command bit 0 already on the line
// SHIFT | 16 bits, each SCLK_HALF cycles low then SCLK_HALF cycles high
// HOLD  | SCLK low for SCLK_HALF cycles after the last high phase
// DONE  | CE low, done pulse, read byte published
module ds1302_xfer #(
  parameter int SCLK_HALF = 50,
  parameter int CE_SETUP  = 200
) (
  input  logic       CLOCK,
  input  logic       RST_n,
  input  logic [7:0] iCall,
  input  logic [7:0] iData,
  output logic       oDone,
  output logic [7:0] oData,
  output logic       RTC_NRST,
  output logic       RTC_SCLK,
  inout  wire        RTC_DATA
);

  localparam int CNT_MAX = (SCLK_HALF > CE_SETUP) ? SCLK_HALF : CE_SETUP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HALF_LD  = CW'(SCLK_HALF - 1);
  // SETUP runs CE_SETUP+1 cycles so done lands CE_SETUP+33*SCLK_HALF+1 after accept
  localparam logic [CW-1:0] SETUP_LD = CW'(CE_SETUP);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic          phase_q;     // 0: low phase, 1: high phase
  logic [15:0]   tx_q;        // {data, command}, sent LSB first
  logic [7:0]    rx_q;
  logic          oe_q;
  logic          dout_q;
  logic          nrst_q;
  logic          sclk_q;
  logic          done_q;
  logic [7:0]    odata_q;
  logic [7:0]    call_cmd;
  logic          is_read;

  assign is_read  = tx_q[0];
  assign RTC_DATA = oe_q ? dout_q : 1'bz;
  assign oDone    = done_q;
  assign oData    = odata_q;
  assign RTC_NRST = nrst_q;
  assign RTC_SCLK = sclk_q;

  // Highest set request bit picks the command byte.
  always_comb begin
    call_cmd = 8'h00;
    if      (iCall[7]) call_cmd = 8'h8E;
    else if (iCall[6]) call_cmd = 8'h84;
    else if (iCall[5]) call_cmd = 8'h82;
    else if (iCall[4]) call_cmd = 8'h80;
    else if (iCall[3]) call_cmd = 8'h8F;
    else if (iCall[2]) call_cmd = 8'h85;
    else if (iCall[1]) call_cmd = 8'h83;
    else if (iCall[0]) call_cmd = 8'h81;
  end

  // Transfer sequencer with registered pin drivers.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      oe_q    <= 1'b0;
      dout_q  <= 1'b0;
      nrst_q  <= 1'b0;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
      odata_q <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iCall != 8'h00) begin
            tx_q    <= {iData, call_cmd};
            nrst_q  <= 1'b1;
            oe_q    <= 1'b1;
            dout_q  <= call_cmd[0];
            sclk_q  <= 1'b0;
            cnt_q   <= SETUP_LD;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            state_q <= SHIFT;
            cnt_q   <= HALF_LD;
            bit_q   <= 4'd0;
            phase_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!phase_q) begin
            // last low-phase cycle: sample read data, then raise SCLK
            phase_q <= 1'b1;
            sclk_q  <= 1'b1;
            cnt_q   <= HALF_LD;
            if (is_read && bit_q[3]) rx_q <= {RTC_DATA, rx_q[7:1]};
          end else begin
            // end of high phase: drop SCLK and present the next bit
            phase_q <= 1'b0;
            sclk_q  <= 1'b0;
            cnt_q   <= HALF_LD;
            if (bit_q == 4'd15) begin
              state_q <= HOLD;
            end else begin
              bit_q  <= bit_q + 4'd1;
              dout_q <= tx_q[bit_q + 4'd1];
              if (is_read && bit_q == 4'd7) oe_q <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            nrst_q  <= 1'b0;
            oe_q    <= 1'b0;
            done_q  <= 1'b1;
            if (is_read) odata_q <= rx_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
